// File: rtl/argmax_onehot_stream_if.sv
// Score-in / result-out handshake bundle for argmax_onehot_stream.
// master = upstream producer and downstream consumer side, slave = the argmax block.
interface argmax_onehot_stream_if #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W      = 32,
  parameter int IDX_W       = $clog2(NUM_CLASSES)
);
  logic                   in_valid;
  logic                   in_ready;
  logic [DATA_W-1:0]      in_data;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [NUM_CLASSES-1:0] out_onehot;
  logic [IDX_W-1:0]       out_index;
  logic [DATA_W-1:0]      out_max;
  logic                   err_len;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_onehot, out_index, out_max, err_len
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_onehot, out_index, out_max, err_len
  );
endinterface

// File: rtl/argmax_onehot_stream.sv
// Streaming argmax: one score per beat, result as one-hot/index/max over valid/ready.
// Optional macro ARGMAX_TIE_LAST_EN: ties select the highest index instead of the lowest.
module argmax_onehot_stream #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W      = 32,
  parameter int SIGNED      = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  argmax_onehot_stream_if.slave  bus
);
  localparam int                     IDX_W       = $clog2(NUM_CLASSES);
  localparam logic [IDX_W-1:0]       LAST_CNT    = IDX_W'(NUM_CLASSES - 1);
  localparam logic [IDX_W-1:0]       IDX_ZERO    = IDX_W'(0);
  localparam logic [IDX_W-1:0]       IDX_ONE     = IDX_W'(1);
  localparam logic [NUM_CLASSES-1:0] ONEHOT_LSB  = NUM_CLASSES'(1);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [IDX_W-1:0]       cnt_r;
  logic [DATA_W-1:0]      max_r;
  logic [IDX_W-1:0]       idx_r;
  logic [DATA_W-1:0]      max_nxt_s;
  logic [IDX_W-1:0]       idx_nxt_s;
  logic [NUM_CLASSES-1:0] out_onehot_r;
  logic [IDX_W-1:0]       out_index_r;
  logic [DATA_W-1:0]      out_max_r;
  logic                   err_len_r;
  logic                   accept_s;
  logic                   last_cnt_s;
  logic                   frame_end_s;
  logic                   in_ready_s;
  logic                   out_valid_s;

  // True when candidate a should replace the running maximum b.
  function automatic logic beats(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic r;
    if (SIGNED != 0) begin
`ifdef ARGMAX_TIE_LAST_EN
      r = ($signed(a) >= $signed(b));
`else
      r = ($signed(a) > $signed(b));
`endif
    end else begin
`ifdef ARGMAX_TIE_LAST_EN
      r = (a >= b);
`else
      r = (a > b);
`endif
    end
    return r;
  endfunction

  // Beat acceptance, frame-end detection and running-max candidate.
  always_comb begin
    accept_s    = bus.in_valid && in_ready_s;
    last_cnt_s  = (cnt_r == LAST_CNT);
    frame_end_s = accept_s && (bus.in_last || last_cnt_s);
    max_nxt_s   = max_r;
    idx_nxt_s   = idx_r;
    if (cnt_r == IDX_ZERO) begin
      max_nxt_s = bus.in_data;
      idx_nxt_s = IDX_ZERO;
    end else if (beats(bus.in_data, max_r)) begin
      max_nxt_s = bus.in_data;
      idx_nxt_s = cnt_r;
    end else begin
      max_nxt_s = max_r;
      idx_nxt_s = idx_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ACCUM;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ACCUM: begin
        if (frame_end_s) state_nxt_s = HOLD;
        else             state_nxt_s = ACCUM;
      end
      HOLD: begin
        if (bus.out_ready) state_nxt_s = ACCUM;
        else               state_nxt_s = HOLD;
      end
      default: state_nxt_s = ACCUM;
    endcase
  end

  // FSM output decode; both flags come straight from the state register.
  always_comb begin
    in_ready_s  = 1'b1;
    out_valid_s = 1'b0;
    case (state_r)
      ACCUM: begin
        in_ready_s  = 1'b1;
        out_valid_s = 1'b0;
      end
      HOLD: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b1;
      end
      default: begin
        in_ready_s  = 1'b1;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // Running max, beat counter and result registers; the frame-end beat's compare is folded in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r        <= IDX_ZERO;
      max_r        <= {DATA_W{1'b0}};
      idx_r        <= IDX_ZERO;
      out_onehot_r <= {NUM_CLASSES{1'b0}};
      out_index_r  <= IDX_ZERO;
      out_max_r    <= {DATA_W{1'b0}};
      err_len_r    <= 1'b0;
    end else begin
      err_len_r <= 1'b0;
      if (accept_s) begin
        max_r <= max_nxt_s;
        idx_r <= idx_nxt_s;
        cnt_r <= frame_end_s ? IDX_ZERO : (cnt_r + IDX_ONE);
      end
      if (frame_end_s) begin
        out_onehot_r <= ONEHOT_LSB << idx_nxt_s;
        out_index_r  <= idx_nxt_s;
        out_max_r    <= max_nxt_s;
        // short frame (last early) or long frame (count reached, no last)
        err_len_r    <= bus.in_last ^ last_cnt_s;
      end
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = out_valid_s;
  assign bus.out_onehot = out_onehot_r;
  assign bus.out_index  = out_index_r;
  assign bus.out_max    = out_max_r;
  assign bus.err_len    = err_len_r;
endmodule

// File: tb/tb_argmax_onehot_stream.sv
// Self-checking bench: an unsigned and a signed instance share one stimulus stream
// and are compared against a loop-based argmax model.
module tb_argmax_onehot_stream;
  localparam int NC = 10;
  localparam int DW = 8;

  typedef logic [24:0] res_t;  // {valid, ready, err, onehot[9:0], index[3:0], max[7:0]}

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_last;
  logic          out_ready;
  logic [DW-1:0] in_data;
  int            n_checks = 0;
  int            n_fail   = 0;

  always #5 clk = ~clk;

  argmax_onehot_stream_if #(.NUM_CLASSES(NC), .DATA_W(DW)) bus_u ();
  argmax_onehot_stream_if #(.NUM_CLASSES(NC), .DATA_W(DW)) bus_s ();

  assign bus_u.in_valid  = in_valid;
  assign bus_u.in_data   = in_data;
  assign bus_u.in_last   = in_last;
  assign bus_u.out_ready = out_ready;
  assign bus_s.in_valid  = in_valid;
  assign bus_s.in_data   = in_data;
  assign bus_s.in_last   = in_last;
  assign bus_s.out_ready = out_ready;

  argmax_onehot_stream #(.NUM_CLASSES(NC), .DATA_W(DW), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .bus(bus_u));
  argmax_onehot_stream #(.NUM_CLASSES(NC), .DATA_W(DW), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .bus(bus_s));

  function automatic res_t snap_u();
    return {bus_u.out_valid, bus_u.in_ready, bus_u.err_len,
            bus_u.out_onehot, bus_u.out_index, bus_u.out_max};
  endfunction

  function automatic res_t snap_s();
    return {bus_s.out_valid, bus_s.in_ready, bus_s.err_len,
            bus_s.out_onehot, bus_s.out_index, bus_s.out_max};
  endfunction

  // Reference argmax over a whole frame using plain integer comparison.
  function automatic int ref_argmax(input logic [7:0] q[$], input bit sgn);
    int best = 0;
    int a;
    int b;
    for (int i = 1; i < q.size(); i++) begin
      a = sgn ? int'({{24{q[i][7]}}, q[i]}) : int'({24'd0, q[i]});
      b = sgn ? int'({{24{q[best][7]}}, q[best]}) : int'({24'd0, q[best]});
`ifdef ARGMAX_TIE_LAST_EN
      if (a >= b) best = i;
`else
      if (a > b) best = i;
`endif
    end
    return best;
  endfunction

  function automatic res_t model_hold(input logic [7:0] q[$], input bit sgn, input bit err);
    int k;
    logic [NC-1:0] oh;
    k = ref_argmax(q, sgn);
    oh = '0;
    oh[k] = 1'b1;
    return {1'b1, 1'b0, err, oh, 4'(k), q[k]};
  endfunction

  task automatic drive_beat(input logic [7:0] d, input logic l, input int gap);
    int waited;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    waited   = 0;
    while (bus_u.in_ready !== 1'b1 && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 64) begin
      n_checks++;
      n_fail++;
      $display("FAIL beat_accept_timeout: in_ready=%b required 1", bus_u.in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] q[$], input bit use_last, input int max_gap);
    for (int i = 0; i < q.size(); i++)
      drive_beat(q[i], use_last && (i == q.size() - 1),
                 (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    res_t exp_r;
    res_t obs;
    exp_r = {1'b0, 1'b1, 1'b0, 10'd0, 4'd0, 8'd0};
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'd0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    obs = snap_u(); n_checks++;
    if (obs !== exp_r) begin n_fail++; $display("FAIL reset_in_u got %h required %h", obs, exp_r); end
    obs = snap_s(); n_checks++;
    if (obs !== exp_r) begin n_fail++; $display("FAIL reset_in_s got %h required %h", obs, exp_r); end
    rst = 1'b1;
    @(negedge clk);
    obs = snap_u(); n_checks++;
    if (obs !== exp_r) begin n_fail++; $display("FAIL reset_out_u got %h required %h", obs, exp_r); end
    obs = snap_s(); n_checks++;
    if (obs !== exp_r) begin n_fail++; $display("FAIL reset_out_s got %h required %h", obs, exp_r); end
  endtask

  task automatic test_directed_unsigned();
    logic [7:0] q[$];
    res_t exp_r;
    res_t obs;
    logic [2:0] post;
    q = '{8'd5, 8'd9, 8'd3, 8'd40, 8'd7, 8'd40, 8'd1, 8'd0, 8'd2, 8'd6};
`ifdef ARGMAX_TIE_LAST_EN
    exp_r = {1'b1, 1'b0, 1'b0, 10'b0000100000, 4'd5, 8'd40};
`else
    exp_r = {1'b1, 1'b0, 1'b0, 10'b0000001000, 4'd3, 8'd40};
`endif
    send_frame(q, 1'b1, 0);
    obs = snap_u(); n_checks++;
    if (obs !== exp_r) begin n_fail++; $display("FAIL directed_u got %h required %h", obs, exp_r); end
    obs = snap_s(); n_checks++;
    if (obs !== exp_r) begin n_fail++; $display("FAIL directed_s got %h required %h", obs, exp_r); end
    release_result();
    obs = snap_u(); post = obs[24:22]; n_checks++;
    if (post !== 3'b010) begin n_fail++; $display("FAIL directed_release got %b required 010", post); end
  endtask

  task automatic test_signed();
    logic [7:0] q[$];
    res_t exp_u;
    res_t exp_s;
    res_t obs;
    q = '{8'h80, 8'h90, 8'hA0, 8'hF0, 8'h85, 8'hC0, 8'hFD, 8'h81, 8'hB0, 8'hFE};
    exp_s = {1'b1, 1'b0, 1'b0, 10'b1000000000, 4'd9, 8'hFE};
    send_frame(q, 1'b1, 0);
    obs = snap_s(); n_checks++;
    if (obs !== exp_s) begin n_fail++; $display("FAIL neg_s got %h required %h", obs, exp_s); end
    obs = snap_u(); n_checks++;
    if (obs !== exp_s) begin n_fail++; $display("FAIL neg_u got %h required %h", obs, exp_s); end
    release_result();
    // 0x7F wins signed, 0x80 wins unsigned
    q = '{8'h7F, 8'h80, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h01};
    exp_s = {1'b1, 1'b0, 1'b0, 10'b0000000001, 4'd0, 8'h7F};
    exp_u = {1'b1, 1'b0, 1'b0, 10'b0000000010, 4'd1, 8'h80};
    send_frame(q, 1'b1, 0);
    obs = snap_s(); n_checks++;
    if (obs !== exp_s) begin n_fail++; $display("FAIL mixed_s got %h required %h", obs, exp_s); end
    obs = snap_u(); n_checks++;
    if (obs !== exp_u) begin n_fail++; $display("FAIL mixed_u got %h required %h", obs, exp_u); end
    release_result();
  endtask

  task automatic test_stall_back_to_back();
    logic [7:0] q[$];
    res_t exp_r;
    res_t obs;
    logic [2:0] post;
    q = '{8'd3, 8'd1, 8'd4, 8'd1, 8'd5, 8'd9, 8'd2, 8'd6, 8'd5, 8'd3};
    exp_r = {1'b1, 1'b0, 1'b0, 10'b0000100000, 4'd5, 8'd9};
    send_frame(q, 1'b1, 0);
    obs = snap_u(); n_checks++;
    if (obs !== exp_r) begin n_fail++; $display("FAIL stall_first got %h required %h", obs, exp_r); end
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b1;
      @(negedge clk);
      obs = snap_u(); n_checks++;
      if (obs !== exp_r) begin n_fail++; $display("FAIL stall_cycle%0d got %h required %h", c, obs, exp_r); end
    end
    in_valid = 1'b0; in_last = 1'b0;
    release_result();
    obs = snap_u(); post = obs[24:22]; n_checks++;
    if (post !== 3'b010) begin n_fail++; $display("FAIL stall_release got %b required 010", post); end
    q = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90, 8'd100};
    exp_r = {1'b1, 1'b0, 1'b0, 10'b1000000000, 4'd9, 8'd100};
    send_frame(q, 1'b1, 0);
    obs = snap_u(); n_checks++;
    if (obs !== exp_r) begin n_fail++; $display("FAIL back_to_back got %h required %h", obs, exp_r); end
    release_result();
  endtask

  task automatic test_short_frame();
    logic [7:0] q[$];
    res_t exp_r;
    res_t obs;
    logic [2:0] post;
    q = '{8'd10, 8'd20, 8'd77, 8'd30, 8'd5};
    exp_r = {1'b1, 1'b0, 1'b1, 10'b0000000100, 4'd2, 8'd77};
    send_frame(q, 1'b1, 0);
    obs = snap_u(); n_checks++;
    if (obs !== exp_r) begin n_fail++; $display("FAIL short_u got %h required %h", obs, exp_r); end
    obs = snap_s(); n_checks++;
    if (obs !== exp_r) begin n_fail++; $display("FAIL short_s got %h required %h", obs, exp_r); end
    @(negedge clk);
    obs = snap_u(); post = obs[24:22]; n_checks++;
    if (post !== 3'b100) begin n_fail++; $display("FAIL short_err_pulse got %b required 100", post); end
    release_result();
  endtask

  task automatic test_long_frame();
    logic [7:0] q[$];
    res_t exp_u;
    res_t exp_s;
    res_t obs;
    q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd200, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10};
    exp_u = {1'b1, 1'b0, 1'b1, 10'b0000010000, 4'd4, 8'd200};
    exp_s = {1'b1, 1'b0, 1'b1, 10'b1000000000, 4'd9, 8'd10};
    send_frame(q, 1'b0, 0);
    obs = snap_u(); n_checks++;
    if (obs !== exp_u) begin n_fail++; $display("FAIL long_u got %h required %h", obs, exp_u); end
    obs = snap_s(); n_checks++;
    if (obs !== exp_s) begin n_fail++; $display("FAIL long_s got %h required %h", obs, exp_s); end
    release_result();
    q = '{8'd50, 8'd40, 8'd30, 8'd20, 8'd10, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1};
    exp_u = {1'b1, 1'b0, 1'b0, 10'b0000000001, 4'd0, 8'd50};
    send_frame(q, 1'b1, 0);
    obs = snap_u(); n_checks++;
    if (obs !== exp_u) begin n_fail++; $display("FAIL after_long got %h required %h", obs, exp_u); end
    release_result();
  endtask

  task automatic test_reset_mid_frame();
    res_t exp_r;
    res_t obs;
    logic [7:0] q[$];
    for (int i = 0; i < 6; i++) drive_beat(8'd250, 1'b0, 0);
    rst = 1'b0;
    #1;
    exp_r = {1'b0, 1'b1, 1'b0, 10'd0, 4'd0, 8'd0};
    obs = snap_u(); n_checks++;
    if (obs !== exp_r) begin n_fail++; $display("FAIL midreset_u got %h required %h", obs, exp_r); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    obs = snap_s(); n_checks++;
    if (obs !== exp_r) begin n_fail++; $display("FAIL midreset_s got %h required %h", obs, exp_r); end
    q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd11};
    exp_r = {1'b1, 1'b0, 1'b0, 10'b1000000000, 4'd9, 8'd11};
    send_frame(q, 1'b1, 0);
    obs = snap_u(); n_checks++;
    if (obs !== exp_r) begin n_fail++; $display("FAIL post_reset_frame got %h required %h", obs, exp_r); end
    release_result();
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    res_t exp_u;
    res_t exp_s;
    res_t obs;
    logic [2:0] post;
    int kind;
    int len;
    bit use_last;
    bit narrow;
    for (int f = 0; f < 100; f++) begin
      kind     = int'($urandom_range(0, 3));
      use_last = (kind != 1);
      len      = (kind == 0) ? int'($urandom_range(2, 9)) : NC;
      narrow   = ($urandom_range(0, 1) == 1);
      q.delete();
      for (int i = 0; i < len; i++)
        q.push_back(narrow ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255)));
      exp_u = model_hold(q, 1'b0, !(use_last && len == NC));
      exp_s = model_hold(q, 1'b1, !(use_last && len == NC));
      send_frame(q, use_last, 2);
      obs = snap_u(); n_checks++;
      if (obs !== exp_u) begin n_fail++; $display("FAIL rand%0d_u got %h required %h", f, obs, exp_u); end
      obs = snap_s(); n_checks++;
      if (obs !== exp_s) begin n_fail++; $display("FAIL rand%0d_s got %h required %h", f, obs, exp_s); end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      release_result();
      obs = snap_u(); post = obs[24:22]; n_checks++;
      if (post !== 3'b010) begin n_fail++; $display("FAIL rand%0d_release got %b required 010", f, post); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_directed_unsigned();
    test_signed();
    test_stall_back_to_back();
    test_short_frame();
    test_long_frame();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
